// File: rtl/neuro_noc_pkg.sv
// neuro_noc_pkg: NoC packet type codes and field-offset helpers shared by PE blocks.
// Packet layout, MSB first: {type[3], seq, dest, source, payload}.
package neuro_noc_pkg;
  typedef enum logic [2:0] {
    DATA       = 3'b000,
    CONF_INB   = 3'b001,
    CONF_W     = 3'b010,
    CONF_AFLUT = 3'b100,
    CONF_AFLB  = 3'b101,
    CONF_AFUB  = 3'b110
  } pkt_type_e;
  localparam int TYPE_W = 3;
  function automatic int dest_lsb(int ns, int pw);
    return pw + $clog2(ns);
  endfunction
  function automatic int seq_lsb(int ns, int pw);
    return pw + 2 * $clog2(ns);
  endfunction
  function automatic int type_lsb(int ns, int pw, int sw);
    return seq_lsb(ns, pw) + sw;
  endfunction
  function automatic int packet_size(int ns, int pw, int sw);
    return type_lsb(ns, pw, sw) + TYPE_W;
  endfunction
endpackage

// File: rtl/distributedRAM_simpleDualPort.sv
// distributedRAM_simpleDualPort: one synchronous write port, one asynchronous read port.
module distributedRAM_simpleDualPort #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/seq_reorder_buffer.sv
// seq_reorder_buffer: buckets packets by sequence number and releases them in order, group by group.
// Optional stall timeout with group abandonment: define SEQ_REORDER_TIMEOUT_EN.
module seq_reorder_buffer
  import neuro_noc_pkg::*;
#(
  parameter int NETWORK_SIZE   = 256,
  parameter int PAYLOAD_WIDTH  = 32,
  parameter int SEQ_WIDTH      = 4,
  parameter int SLOTS          = NETWORK_SIZE,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int SOURCE_WIDTH  = $clog2(NETWORK_SIZE),
  localparam int PACKET_SIZE   = packet_size(NETWORK_SIZE, PAYLOAD_WIDTH, SEQ_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PACKET_SIZE-1:0]               in_packet,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2:0]                           out_type,
  output logic [SEQ_WIDTH-1:0]                 out_seq,
  output logic [SOURCE_WIDTH+PAYLOAD_WIDTH-1:0] out_data,
  output logic                                 out_last,
  output logic [SOURCE_WIDTH:0]                group_size,
  output logic                                 seq_skip
);
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int NB     = 2**SEQ_WIDTH;
  localparam int DW     = TYPE_W + SOURCE_WIDTH + PAYLOAD_WIDTH;
  localparam int SEQ_L  = seq_lsb(NETWORK_SIZE, PAYLOAD_WIDTH);
  localparam int TYPE_L = type_lsb(NETWORK_SIZE, PAYLOAD_WIDTH, SEQ_WIDTH);
  localparam int DEST_L = dest_lsb(NETWORK_SIZE, PAYLOAD_WIDTH);
  typedef enum logic {WAIT, SEND} state_e;
  logic [SLOT_W:0]         wcnt_q [NB];
  logic [SLOT_W:0]         wcnt_d [NB];
  logic [SLOT_W:0]         rd_idx_q, rd_idx_d;
  logic [SEQ_WIDTH-1:0]    cur_seq_q, cur_seq_d, in_seq;
  logic [SOURCE_WIDTH:0]   group_size_q, group_size_d;
  logic [SOURCE_WIDTH-1:0] out_src;
  logic [SLOT_W-1:0]       wr_slot;
  logic [DW-1:0]           rd_word;
  state_e                  state_q, state_d;
  logic                    wr_en, out_fire, done, advance, timeout, unused_dest;
  assign in_seq      = in_packet[SEQ_L +: SEQ_WIDTH];
  assign unused_dest = ^in_packet[DEST_L +: SOURCE_WIDTH];
  assign in_ready    = wcnt_q[in_seq] != (SLOT_W+1)'(SLOTS);
  assign wr_en       = in_valid && in_ready;
  // A packet for the bucket being retired this cycle starts its next lap at slot 0.
  assign wr_slot     = (advance && in_seq == cur_seq_q) ? '0 : wcnt_q[in_seq][SLOT_W-1:0];
  distributedRAM_simpleDualPort #(.DATA_WIDTH(DW), .ADDR_WIDTH(SEQ_WIDTH + SLOT_W)) u_store (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i ({in_seq, wr_slot}),
    .wdata_i ({in_packet[TYPE_L +: TYPE_W], in_packet[SOURCE_WIDTH+PAYLOAD_WIDTH-1:0]}),
    .raddr_i ({cur_seq_q, rd_idx_q[SLOT_W-1:0]}),
    .rdata_o (rd_word)
  );
  assign {out_type, out_data} = rd_word;
  assign out_src    = out_data[PAYLOAD_WIDTH +: SOURCE_WIDTH];
  assign out_seq    = cur_seq_q;
  assign group_size = group_size_q;
  assign out_valid  = state_q == SEND;
  assign out_fire   = out_valid && out_ready;
  assign done       = out_type != DATA || int'(rd_idx_q) + 1 == int'(group_size_q);
  assign out_last   = out_valid && done;
  assign advance    = (out_fire && done) || timeout;
`ifdef SEQ_REORDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stall_q;
  assign timeout  = !out_valid && stall_q == TW'(TIMEOUT_CYCLES - 1);
  assign seq_skip = timeout;
  // Back-pressured cycles hold the count: the group is not starved, downstream is.
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_q <= '0;
    else stall_q <= (advance || out_fire) ? '0 : out_valid ? stall_q : stall_q + 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign seq_skip       = 1'b0;
`endif
  always_comb begin
    wcnt_d       = wcnt_q;
    rd_idx_d     = rd_idx_q;
    cur_seq_d    = cur_seq_q;
    group_size_d = group_size_q;
    if (wr_en) wcnt_d[in_seq] = wcnt_q[in_seq] + 1'b1;
    if (out_fire && out_type == CONF_INB)
      group_size_d = (out_src == '0) ? (SOURCE_WIDTH+1)'(1) : {1'b0, out_src};
    if (advance) begin
      wcnt_d[cur_seq_q] = (wr_en && in_seq == cur_seq_q) ? (SLOT_W+1)'(1) : '0;
      cur_seq_d         = cur_seq_q + 1'b1;
      rd_idx_d          = '0;
    end else if (out_fire) rd_idx_d = rd_idx_q + 1'b1;
    // Registered out_valid: SEND exactly when the next cycle has an unread packet.
    state_d = (rd_idx_d < wcnt_d[cur_seq_d]) ? SEND : WAIT;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wcnt_q       <= '{default: '0};
      rd_idx_q     <= '0;
      cur_seq_q    <= '0;
      group_size_q <= (SOURCE_WIDTH+1)'(1);
      state_q      <= WAIT;
    end else begin
      wcnt_q       <= wcnt_d;
      rd_idx_q     <= rd_idx_d;
      cur_seq_q    <= cur_seq_d;
      group_size_q <= group_size_d;
      state_q      <= state_d;
    end
endmodule
